// File: rtl/mem_a_pkg.sv
// Shared constants, element type and helpers for the A staging memory.
// MEM_A_VALID_EN adds a per-row valid output.
package mem_a_pkg;

    localparam int A_BITS_AB = 8;
    localparam int A_DIM     = 8;

    typedef logic signed [A_BITS_AB-1:0] a_elem_t;

    function automatic int row_w(input int dim);
        return (dim < 2) ? 1 : $clog2(dim);
    endfunction

endpackage

// File: rtl/mem_a_row.sv
// One skewed row chain: DIM data stages preceded by ROW skew slots.
// MEM_A_VALID_EN adds a valid bit that travels with every stage.
module mem_a_row
    import mem_a_pkg::*;
#(
    parameter int BITS_AB = A_BITS_AB,
    parameter int DIM     = A_DIM,
    parameter int ROW     = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic                      shift,
    input  logic signed [BITS_AB-1:0] din [DIM-1:0],
`ifdef MEM_A_VALID_EN
    output logic                      vout,
`endif
    output logic signed [BITS_AB-1:0] dout
);

    localparam int LEN = DIM + ROW;

    logic signed [BITS_AB-1:0] r [LEN-1:0];

    // Load wins over shift so a reloaded row restarts its skew.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int j = 0; j < LEN; j++) begin
                r[j] <= '0;
            end
        end else if (load) begin
            for (int j = 0; j < ROW; j++) begin
                r[j] <= '0;
            end
            for (int k = 0; k < DIM; k++) begin
                r[ROW+k] <= din[k];
            end
        end else if (shift) begin
            for (int j = 0; j < LEN - 1; j++) begin
                r[j] <= r[j+1];
            end
            r[LEN-1] <= '0;
        end
    end

    assign dout = r[0];

`ifdef MEM_A_VALID_EN
    logic [LEN-1:0] v;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            v <= '0;
        end else if (load) begin
            for (int j = 0; j < LEN; j++) begin
                v[j] <= (j >= ROW);
            end
        end else if (shift) begin
            v <= v >> 1;
        end
    end

    assign vout = v[0];
`endif

endmodule

// File: rtl/mem_a.sv
// A-matrix staging memory feeding a DIM x DIM systolic array, row i skewed by i.
// MEM_A_VALID_EN adds Avalid, marking real data on each row head.
module mem_a
    import mem_a_pkg::*;
#(
    parameter int BITS_AB = A_BITS_AB,
    parameter int DIM     = A_DIM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         WrEn,
    input  logic signed [BITS_AB-1:0]    Ain  [DIM-1:0],
    input  logic [row_w(DIM)-1:0]        Arow,
`ifdef MEM_A_VALID_EN
    output logic [DIM-1:0]               Avalid,
`endif
    output logic signed [BITS_AB-1:0]    Aout [DIM-1:0]
);

    // Out-of-range Arow matches no row, so the load is dropped.
    logic [DIM-1:0] row_load;

    for (genvar i = 0; i < DIM; i++) begin : g_row
        assign row_load[i] = WrEn && (32'(Arow) == i);

        mem_a_row #(
            .BITS_AB (BITS_AB),
            .DIM     (DIM),
            .ROW     (i)
        ) u_row (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (row_load[i]),
            .shift (en),
            .din   (Ain),
`ifdef MEM_A_VALID_EN
            .vout  (Avalid[i]),
`endif
            .dout  (Aout[i])
        );
    end

endmodule

// File: tb/tb_mem_a.sv
// Scoreboard bench for mem_a: expected heads derive from the skewed stream formula.
// Define MEM_A_VALID_EN to also check Avalid.
module tb_mem_a;
    import mem_a_pkg::*;

    localparam int DIM  = A_DIM;
    localparam int BITS = A_BITS_AB;
    localparam int RW   = row_w(A_DIM);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en    = 1'b0;
    logic          WrEn  = 1'b0;
    logic [RW-1:0] Arow  = '0;
    a_elem_t       Ain  [DIM-1:0];
    a_elem_t       Aout [DIM-1:0];
`ifdef MEM_A_VALID_EN
    logic [DIM-1:0] Avalid;
`endif

    mem_a #(
        .BITS_AB (BITS),
        .DIM     (DIM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .WrEn   (WrEn),
        .Ain    (Ain),
        .Arow   (Arow),
`ifdef MEM_A_VALID_EN
        .Avalid (Avalid),
`endif
        .Aout   (Aout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DIM-1:0][BITS-1:0] a;
        logic [DIM-1:0]           v;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pat   [DIM];
    int   mdl_a [DIM][DIM];
    bit   loaded[DIM];
    int   cnt   [DIM];

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic bit exp_v(input int i);
        int d;
        d = cnt[i] - i;
        return loaded[i] && d >= 0 && d < DIM;
    endfunction

    function automatic int exp_a(input int i);
        if (exp_v(i)) return mdl_a[i][cnt[i]-i];
        return 0;
    endfunction

    task automatic push_exp();
        exp_t e;
        for (int i = 0; i < DIM; i++) begin
            e.a[i] = BITS'(exp_a(i));
            e.v[i] = exp_v(i);
        end
        sbq.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, " empty"}, 0, 1);
            return;
        end
        e = sbq.pop_front();
        for (int i = 0; i < DIM; i++) begin
            check($sformatf("%s a%0d", tag, i),
                  int'(Aout[i]), int'($signed(e.a[i])));
`ifdef MEM_A_VALID_EN
            check($sformatf("%s v%0d", tag, i),
                  int'(Avalid[i]), int'(e.v[i]));
`endif
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DIM; i++) begin
            loaded[i] = 1'b0;
            cnt[i]    = 0;
        end
    endtask

    task automatic step(input bit we, input int row,
                        input bit e, input string tag);
        @(negedge clk);
        WrEn = we;
        Arow = RW'(row);
        en   = e;
        for (int k = 0; k < DIM; k++) Ain[k] = BITS'(pat[k]);
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < DIM; i++) begin
                if (we && i == row) begin
                    loaded[i] = 1'b1;
                    cnt[i]    = 0;
                    for (int k = 0; k < DIM; k++) mdl_a[i][k] = pat[k];
                end else if (e) begin
                    cnt[i]++;
                end
            end
        end
        push_exp();
        #1;
        pop_cmp(tag);
    endtask

    task automatic load_all(input int base, input string tag);
        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) pat[k] = base + 10 * i + k;
            step(1'b1, i, 1'b0, tag);
        end
    endtask

    initial begin
        for (int k = 0; k < DIM; k++) begin
            Ain[k] = '0;
            pat[k] = 0;
        end
        model_reset();

        #1;
        push_exp();
        pop_cmp("rst_init");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;

        for (int k = 0; k < DIM; k++) pat[k] = k;
        step(1'b1, 0, 1'b0, "load0");
        for (int n = 0; n < DIM; n++) step(1'b0, 0, 1'b1, "drain0");

        load_all(0, "full_ld");
        for (int n = 0; n < 3; n++) step(1'b0, 0, 1'b1, "full_dr");
        check("n3 lit a0", int'(Aout[0]), 3);
        check("n3 lit a3", int'(Aout[3]), 30);
        check("n3 lit a4", int'(Aout[4]), 0);
        for (int n = 0; n < 2; n++) step(1'b0, 0, 1'b1, "full_dr");
        for (int n = 0; n < 5; n++) step(1'b0, 0, 1'b0, "hold");
        for (int n = 0; n < 12; n++) step(1'b0, 0, 1'b1, "full_tail");

        load_all(0, "sim_ld");
        for (int n = 0; n < 3; n++) step(1'b0, 0, 1'b1, "sim_pre");
        for (int k = 0; k < DIM; k++) pat[k] = 90 + k;
        step(1'b1, 2, 1'b1, "simul");
        check("simul lit a2", int'(Aout[2]), 0);
        for (int n = 0; n < 2 * DIM; n++) step(1'b0, 0, 1'b1, "sim_dr");

        for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) pat[k] = ((k + i) % 2) ? 127 : -128;
            step(1'b1, i, 1'b0, "sgn_ld");
        end
        for (int n = 0; n < 2 * DIM; n++) step(1'b0, 0, 1'b1, "sgn_dr");

        load_all(0, "rst_ld");
        for (int n = 0; n < 3; n++) step(1'b0, 0, 1'b1, "rst_pre");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        model_reset();
        push_exp();
        pop_cmp("rst_async");
        for (int n = 0; n < 2; n++) step(1'b0, 0, 1'b1, "rst_hold");
        @(negedge clk);
        rst_n = 1'b0;
        for (int n = 0; n < 3; n++) step(1'b0, 0, 1'b1, "rst_post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_a.md
Name: mem_a

Overview:
- A-matrix staging memory for a DIM x DIM signed systolic-array matrix multiplier.
- Software/MMIO loads one full row of A per cycle.
- During compute, each enabled cycle emits one element per row. Outputs are diagonally skewed: row i lags row 0 by i cycles, which is the order the systolic array consumes them.

Parameters:
- BITS_AB, 8, width of each signed A element.
- DIM, 8, matrix dimension (number of rows and columns). Must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-HIGH. The port keeps the codebase name rst_n, but asserting it (1) resets the block.
- en  in  1  advance: every row shifts one element toward its output.
- WrEn  in  1  load the row selected by Arow with Ain.
- Ain  in  DIM x BITS_AB signed (unpacked [DIM-1:0])  row data; Ain[k] is column k.
- Arow  in  $clog2(DIM)  row index to load.
- Aout  out  DIM x BITS_AB signed (unpacked [DIM-1:0])  current head element of each row.

Behaviour:
- Storage: row i is a register chain r[i][0 .. DIM+i-1] of BITS_AB-bit values. Row 0 has DIM stages; row DIM-1 has 2*DIM-1 stages.
- Aout[i] = r[i][0], driven directly from the register with no combinational path from inputs.
- Reset (rst_n=1, asynchronous): every r[i][j] is cleared to 0, so all Aout are 0 immediately and hold 0 while reset is asserted. Reset during a load or drain discards all contents.
- Load, on a clock edge with WrEn=1 and Arow=i:
  - r[i][i+k] <= Ain[k] for k = 0..DIM-1.
  - r[i][0..i-1] <= 0 (these are the skew slots).
  - Other rows are not affected by the load.
- Shift, on a clock edge with en=1, for each row not being loaded that cycle:
  - r[i][j] <= r[i][j+1].
  - Tail r[i][DIM+i-1] <= 0 (zero fill).
- Simultaneous WrEn and en: the addressed row loads and does not shift; all other rows shift.
- Neither WrEn nor en: all state holds.
- Arow >= DIM (possible only when DIM is not a power of 2): the load is ignored.
- Resulting stream after loading all rows, on the n-th enabled cycle (n=0 is the state before the first en):
  - Aout[i] = A[i][n-i] for i <= n <= i+DIM-1, and 0 otherwise.
  - A full drain takes 2*DIM-1 en cycles, after which all outputs are 0.
- Latency: a loaded value appears on Aout the cycle after the load edge (row 0 column 0 is visible immediately after its load).
- Arithmetic: none; values are stored bit-exact, sign preserved.

Optional Feature:
- MEM_A_VALID_EN: adds output port Avalid [DIM-1:0]. A valid bit travels with each chain stage:
  - Set for the loaded stages.
  - Cleared for skew and zero-fill stages.
  - Cleared on reset.
  - Avalid[i] = valid of r[i][0].
- Without the macro: no Avalid port and no valid storage.

Decomposition:
- Package mem_a_pkg holds:
  - default constants A_BITS_AB=8 and A_DIM=8;
  - typedef a_elem_t (logic signed [BITS_AB-1:0]);
  - the helper function for the row-index width.
- Sub-module mem_a_row: parameterized by BITS_AB, DIM and ROW (chain length DIM+ROW), with ports clk, rst_n, load, shift, din[DIM] and dout. mem_a generates DIM instances and decodes Arow into per-row load strobes.

Test Plan:
- Reset: assert rst_n=1 mid-operation with rows loaded -> all Aout=0 at once, and they stay 0 after release until the next load.
- Single row load: WrEn=1, Arow=0, Ain={7,6,5,4,3,2,1,0} (Ain[k]=k) -> next cycle Aout[0]=0. With en=1 for 7 cycles, Aout[0] = 1,2,...,7, then 0. All other Aout stay 0.
- Full load of 8 rows with Ain[k]=10*i+k, then en for 15 cycles:
  - cycle n: Aout[i] = 10*i+(n-i) when 0 <= n-i <= 7, else 0;
  - e.g. n=3 gives Aout = {0,0,0,0,30,21,12,3}.
- Hold: en=0 and WrEn=0 for 5 cycles mid-drain -> Aout unchanged.
- Simultaneous: WrEn=1 with Arow=2 and en=1 -> row 2 reloads (Aout[2]=0, with skew restored) while rows 0,1,3..7 shift by one.
- Signed values: load Ain with -128 and 127 -> emitted bit-exact as -128 and 127. With MEM_A_VALID_EN, Avalid[i]=1 exactly on the 8 data cycles of row i.
